// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface muldiv_unit_if #(
  parameter int unsigned N = 32
) ();
  logic         start;
  logic [2:0]   funct3;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  // Datapath side drives requests and observes status.
  modport master (
    output start, funct3, a, b,
    input  busy, done, result
  );

  // Unit side.
  modport slave (
    input  start, funct3, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// unsigned magnitudes, one bit per cycle, with sign correction on completion.
module muldiv_unit #(
  parameter int unsigned N = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [2:0]     r_op;
  logic           r_neg;
  logic [CntW-1:0] r_cnt;
  logic [N-1:0]   r_mcand;   // multiplicand magnitude
  logic [N-1:0]   r_div;     // divisor magnitude
  logic [N-1:0]   r_quo;     // dividend bits shift out, quotient bits shift in
  logic [N-1:0]   r_rem;
  logic [2*N-1:0] r_acc;     // high half: partial product, low half: multiplier
  logic [N-1:0]   r_result;

  logic           w_accept;
  logic           w_div_zero;
  logic           w_last;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [N-1:0]   w_a_mag;
  logic [N-1:0]   w_b_mag;
  logic           w_neg;
  logic [N:0]     w_sum;
  logic [2*N-1:0] w_acc_nxt;
  logic [N:0]     w_rem_shift;
  logic           w_ge;
  logic [N-1:0]   w_rem_nxt;
  logic [N-1:0]   w_quo_nxt;
  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_final;
  logic           w_busy;
  logic           w_done;

  assign w_accept   = bus.start && (r_state != StRun);
  assign w_div_zero = bus.funct3[2] && (bus.b == '0);
  assign w_last     = (r_state == StRun) && (r_cnt == CntW'(N - 1));

  // Operand signedness, magnitudes and result sign for the incoming request.
  always_comb begin
    // a is signed except for MULHU/DIVU/REMU; b is signed for MUL/MULH/DIV/REM only.
    w_a_neg = bus.a[N-1] && !(bus.funct3[0] && (bus.funct3[1] || bus.funct3[2]));
    w_b_neg = bus.b[N-1] && (bus.funct3[2] ? !bus.funct3[0] : !bus.funct3[1]);
    w_a_mag = w_a_neg ? -bus.a : bus.a;
    w_b_mag = w_b_neg ? -bus.b : bus.b;
    // Remainder takes the dividend's sign.
    w_neg   = (bus.funct3[2] && bus.funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  end

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    w_sum       = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_acc_nxt   = {w_sum, r_acc[N-1:1]};
    w_rem_shift = {r_rem, r_quo[N-1]};
    w_ge        = w_rem_shift >= {1'b0, r_div};
    w_rem_nxt   = w_ge ? N'(w_rem_shift - {1'b0, r_div}) : w_rem_shift[N-1:0];
    w_quo_nxt   = {r_quo[N-2:0], w_ge};
  end

  // Sign correction and result selection for the final iteration.
  always_comb begin
    w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
    unique case (r_op)
      3'b000:                 w_final = w_prod[N-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[2*N-1:N];
      3'b100, 3'b101:         w_final = r_neg ? -w_quo_nxt : w_quo_nxt;
      default:                w_final = r_neg ? -w_rem_nxt : w_rem_nxt;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; divide by zero bypasses RUN.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (bus.start) w_state_nxt = w_div_zero ? StDone : StRun;
        else           w_state_nxt = StIdle;
      end
      StRun:   if (w_last) w_state_nxt = StDone;
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_busy = (r_state == StRun);
    w_done = (r_state == StDone);
  end

  // Operand latch and per-cycle iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_div   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_op    <= bus.funct3;
      r_neg   <= w_neg;
      r_cnt   <= '0;
      r_mcand <= w_a_mag;
      r_div   <= w_b_mag;
      r_quo   <= w_a_mag;
      r_rem   <= '0;
      r_acc   <= {{N{1'b0}}, w_b_mag};
    end else if (r_state == StRun) begin
      r_cnt   <= r_cnt + 1'b1;
      r_quo   <= w_quo_nxt;
      r_rem   <= w_rem_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // Result register: loaded on completion or on the divide-by-zero fast path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (w_accept && w_div_zero) begin
      r_result <= bus.funct3[1] ? bus.a : '1;
    end else if (w_last) begin
      r_result <= w_final;
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus hand-written corner sequences.
module tb_muldiv_unit;
  localparam int unsigned N = 32;
  localparam int          Lat = 33;
  localparam int          Budget = 100;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  muldiv_unit_if #(.N(N)) bus ();

  muldiv_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model built on native signed/unsigned 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drive a request at the current negedge; start stays high until the caller drops it.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    bus.start  = 1'b1;
    if (push) exp_q.push_back(exp);
  endtask

  // Drop start and scramble operands to prove they were latched.
  task automatic release_start();
    bus.start  = 1'b0;
    bus.a      = $urandom;
    bus.b      = $urandom;
    bus.funct3 = 3'($urandom);
  endtask

  // Wait at negedges for done, tracking cycles since the accepting edge.
  task automatic wait_done(input int lat0, output int lat, output bit busy_ok);
    lat = lat0;
    busy_ok = 1'b1;
    while (!bus.done && lat < Budget) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  // Compare a completed operation against the scoreboard head.
  task automatic finish_op(input string name, input int lat, input int exp_lat,
                           input bit busy_ok);
    if (!bus.done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: done not seen in %0d cycles, required at %0d", name, lat,
               exp_lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check({name, " result"}, bus.result, exp_q.pop_front());
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " busy at done"}, {31'd0, bus.busy}, 32'd0);
      if (exp_lat > 1) check({name, " busy during run"}, {31'd0, busy_ok}, 32'd1);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit busy_ok;
    int exp_lat;
    exp_lat = (v.f3[2] && v.b == 0) ? 1 : Lat;
    @(negedge clk);
    issue(v.f3, v.a, v.b, v.exp, 1'b1);
    @(negedge clk);
    release_start();
    if (exp_lat == 1) check({v.name, " no busy"}, {31'd0, bus.busy}, 32'd0);
    wait_done(1, lat, busy_ok);
    finish_op(v.name, lat, exp_lat, busy_ok);
    @(negedge clk);
    check({v.name, " done pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit seen;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs.push_back('{"mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{"mulh", 3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
    vecs.push_back('{"mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{"mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF});
    vecs.push_back('{"div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
    vecs.push_back('{"rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
    vecs.push_back('{"divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC});
    vecs.push_back('{"divu by 0", 3'b101, 32'h1234, 32'd0, 32'hFFFF_FFFF});
    vecs.push_back('{"rem by 0", 3'b110, 32'h1234, 32'd0, 32'h1234});
    vecs.push_back('{"div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{"rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
    for (int i = 0; i < 8; i++) begin
      rf3 = 3'(i);
      ra  = $urandom;
      rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      vecs.push_back('{$sformatf("rand%0d", i), rf3, ra, rb, model(rf3, ra, rb)});
    end

    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.a      = '0;
    bus.b      = '0;

    // Reset state.
    #1;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back issue from DONE.
    @(negedge clk);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    @(negedge clk);
    release_start();
    wait_done(1, lat, busy_ok);
    finish_op("b2b first", lat, Lat, busy_ok);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    @(negedge clk);
    release_start();
    check("b2b second accepted", {31'd0, bus.busy}, 32'd1);
    wait_done(1, lat, busy_ok);
    finish_op("b2b second", lat, Lat, busy_ok);
    @(negedge clk);

    // Back-to-back divide by zero: done stays high for two cycles.
    issue(3'b101, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    check("dz b2b done1", {31'd0, bus.done}, 32'd1);
    check("dz b2b result1", bus.result, exp_q.pop_front());
    issue(3'b111, 32'h55, 32'd0, 32'h55, 1'b1);
    @(negedge clk);
    release_start();
    check("dz b2b done2", {31'd0, bus.done}, 32'd1);
    check("dz b2b result2", bus.result, exp_q.pop_front());
    @(negedge clk);
    check("dz b2b idle", {31'd0, bus.done | bus.busy}, 32'd0);

    // Start during RUN is ignored.
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    @(negedge clk);
    release_start();
    repeat (9) @(negedge clk);
    issue(3'b101, 32'd100, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    release_start();
    wait_done(11, lat, busy_ok);
    finish_op("start in run", lat, Lat, busy_ok);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("start in run not queued", {31'd0, seen}, 32'd0);

    // Reset mid-RUN aborts with no done pulse.
    issue(3'b001, 32'h1357_9BDF, 32'h2468_ACE0, 32'd0, 1'b0);
    @(negedge clk);
    release_start();
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort no done", {31'd0, seen}, 32'd0);

    // Recovery after abort.
    run_vec('{"after abort", 3'b000, 32'd12345, 32'd678, 32'd8369910});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
